// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the core memory bus arbiter: FSM states, grant owner and access sizes.
package mem_bus_arbiter_pkg;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_t;

  typedef enum logic {
    GrantFetch,
    GrantData
  } grant_t;

  // Winner when both ports request in the same IDLE cycle.
  function automatic grant_t tie_winner(input bit prio_data, input grant_t last_grant);
    if (prio_data) begin
      return GrantData;
    end
    return (last_grant == GrantFetch) ? GrantData : GrantFetch;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Watchdog for a stuck bus transaction: saturating BUSY-cycle counter with a sticky error flag.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic err_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, clear_i, enable_i};
    assign err_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != Limit)) begin
        cnt_d = cnt_q + CntW'(1);
      end
      // Error is sticky; only reset clears it.
      err_d = err_q | (cnt_d == Limit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign err_o = err_q;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the data stage,
// latching the granted request and steering the completion back to its owner.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit          PRIO_DATA = 1'b1,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        if_valid,
  input  logic [63:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ok,

  input  logic        dm_valid,
  input  logic        dm_write,
  input  logic [63:0] dm_addr,
  input  logic [2:0]  dm_size,
  input  logic [7:0]  dm_strobe,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_ok,

  output logic        bus_valid,
  output logic        bus_write,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ok,

  output logic        err
);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d;

  logic        grant_valid;
  grant_t      grant_sel;

  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;

  // Arbitration only happens from IDLE, so grants are at least two cycles apart.
  always_comb begin
    grant_valid = (state_q == StIdle) && (if_valid || dm_valid);
    grant_sel   = GrantFetch;
    if (if_valid && dm_valid) begin
      grant_sel = tie_winner(PRIO_DATA, last_grant_q);
    end else if (dm_valid) begin
      grant_sel = GrantData;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = (grant_sel == GrantData) ? StBusyD : StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        if (bus_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    if (grant_valid) begin
      last_grant_d = grant_sel;
      if (grant_sel == GrantData) begin
        write_d  = dm_write;
        addr_d   = dm_addr;
        size_d   = dm_size;
        strobe_d = dm_strobe;
        wdata_d  = dm_wdata;
      end else begin
        write_d  = 1'b0;
        addr_d   = if_addr;
        size_d   = MSIZE4;
        strobe_d = '0;
        wdata_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_grant_q <= GrantFetch;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
    end
  end

  // Completion is a same-cycle pass-through of bus_ok to the owning port only.
  always_comb begin
    bus_valid  = (state_q != StIdle);
    bus_write  = write_q;
    bus_addr   = addr_q;
    bus_size   = size_q;
    bus_strobe = strobe_q;
    bus_wdata  = wdata_q;
    if_ok      = (state_q == StBusyI) && bus_ok;
    dm_ok      = (state_q == StBusyD) && bus_ok;
    if_data    = '0;
    dm_rdata   = '0;
    if (if_ok) begin
      if_data = addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
    end
    if (dm_ok) begin
      dm_rdata = bus_rdata;
    end
  end

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i (grant_valid),
    .enable_i((state_q != StIdle) && !bus_ok),
    .err_o   (err)
  );

endmodule
